gpr_mp: RTL
===========

# gpr_mp

Parametrised multi-port general-purpose register file for the multi-cycle and pipelined CPU cores. It provides NRD combinational read ports, two write ports with fixed priority, and a per-register busy scoreboard so the control unit can stall on read-after-write and write-after-write hazards. It replaces the single-write, two-read GPR in the datapath between decode (read/issue) and writeback (write/clear).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
- NRD, 2, number of read ports (≥1)
- ZERO_REG, 1, 1 = register 0 reads 0, is never written and is never busy; 0 = register 0 is ordinary
- clock  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- rd_addr  in  NRD*ADDR_W  packed read indices; port i = bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  packed read data, combinational
- rd_busy  out  NRD  scoreboard bit of each read index, combinational
- we0, waddr0, wdata0  in  1/ADDR_W/DATA_W  write port 0 (ALU writeback)
- we1, waddr1, wdata1  in  1/ADDR_W/DATA_W  write port 1 (load/multicycle writeback), higher priority
- iss_valid  in  1  request to mark iss_addr busy (instruction issued with destination)
- iss_addr  in  ADDR_W  destination index being issued
- iss_ready  out  1  issue accepted this cycle (no WAW hazard)
- busy_cnt  out  ADDR_W+1  number of busy registers, registered

## Operation
- Reset (rst_n low at rising edge): all registers ← 0, all busy ← 0, busy_cnt ← 0. Writes and issues in a reset cycle are ignored. Reset mid-operation discards outstanding busy bits.
- Write: on the edge, each enabled port writes its index. Same index on both ports → port 1 wins. ZERO_REG=1 and index 0 → write dropped.
- Clear: each enabled write port clears busy[waddr] on the edge.
- Issue: iss_ready = iss_valid && !busy[iss_addr] || (iss_valid && clear of iss_addr this cycle). Accepted issue sets busy[iss_addr]. Set and clear of the same index in one cycle → set wins. ZERO_REG=1 and iss_addr 0 → iss_ready=1, no bit set.
- Read: rd_data[i] = reg[rd_addr[i]]; ZERO_REG=1 and index 0 → 0, rd_busy 0.
- busy_cnt = population count of busy vector after the edge; never exceeds DEPTH (or DEPTH-1 with ZERO_REG).

## Timing
- Read latency 0 (combinational from rd_addr and state).
- Write visible on rd_data the cycle after the edge (see Configuration for same-cycle).
- Busy set visible on rd_busy the cycle after an accepted issue; clear likewise.
- busy_cnt updates with the same edge as the busy vector.
- No ready/valid backpressure on write ports; writes are always accepted.

## Configuration
- GPR_BYPASS_EN defined: read port i whose index matches an enabled write this cycle returns that write's data (port 1 over port 0), and rd_busy[i] reads 0 for that index; index 0 excluded when ZERO_REG=1.
- Undefined: reads return stored value; rd_busy reflects stored busy bit only.

## Structure
- Package gpr_pkg: default DATA_W/ADDR_W, register-index typedef, popcount function.
- Sub-module gpr_scoreboard: busy vector, set/clear priority, iss_ready, busy_cnt. Storage and read muxing in gpr_mp.

## Test plan
- Reset then read all 32 indices on both ports → rd_data 0, rd_busy 0, busy_cnt 0.
- we0=1 waddr0=5 wdata0=0xDEADBEEF, next cycle rd_addr0=5 → 0xDEADBEEF; same cycle read → old 0 without GPR_BYPASS_EN, 0xDEADBEEF with it.
- we0 and we1 both to index 7 with 0x11 and 0x22 → reg7 = 0x22; write to index 0 → reads 0.
- Issue 9 → iss_ready 1, next cycle rd_busy 1, busy_cnt 1; re-issue 9 → iss_ready 0; we1 to 9 with iss_valid/iss_addr=9 same cycle → iss_ready 1, busy stays 1.
- Issue indices 1..31 over 31 cycles → busy_cnt 31; assert rst_n low one cycle → busy_cnt 0, all rd_busy 0, reg contents 0.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared defaults, register-index type and popcount helper for the gpr_mp register file.
// Optional feature macro used by this slice: GPR_BYPASS_EN (same-cycle write-to-read forwarding).
package gpr_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Widest busy vector popcount supports; callers zero-extend with a size cast (ADDR_W <= 8).
    localparam int POP_MAX = 256;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy scoreboard: issue sets a bit, writeback clears it, set beats clear.
// Keeps a registered count of busy registers alongside the vector.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  clr0_en,
    input  logic [ADDR_W-1:0]     clr0_addr,
    input  logic                  clr1_en,
    input  logic [ADDR_W-1:0]     clr1_addr,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  iss_ready,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] set_vec;
    logic [ADDR_W:0]  cnt_q;
    logic             iss_zero;

    // Issue handshake: iss_ready is combinational from iss_valid, iss_addr, the stored busy
    // bits and this cycle's writeback clears; an issue is taken exactly when
    // iss_valid && iss_ready at the rising edge. There is no holding or queuing of issues.
    always_comb begin
        clr_vec = '0;
        if (clr0_en) clr_vec = clr_vec | (DEPTH'(1) << clr0_addr);
        if (clr1_en) clr_vec = clr_vec | (DEPTH'(1) << clr1_addr);

        iss_zero  = ZR && (iss_addr == '0);
        iss_ready = iss_valid && (iss_zero || !busy_q[iss_addr] || clr_vec[iss_addr]);

        set_vec = '0;
        if (iss_ready && !iss_zero) set_vec = DEPTH'(1) << iss_addr;

        busy_nxt = (busy_q & ~clr_vec) | set_vec;
        if (ZR) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
            cnt_q  <= (ADDR_W+1)'(popcount(POP_MAX'(busy_nxt)));
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/gpr_mp.sv
// Multi-port GPR: NRD combinational read ports, two prioritised write ports, busy scoreboard.
// Define GPR_BYPASS_EN to forward same-cycle write data (and a cleared busy bit) to readers.
module gpr_mp
    import gpr_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  iss_ready,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr0_ok;
    logic              wr1_ok;

    assign wr0_ok = we0 && !(ZR && (waddr0 == '0));
    assign wr1_ok = we1 && !(ZR && (waddr1 == '0));

    // Port 1 is written last so it wins when both ports target the same index.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            if (wr0_ok) mem[waddr0] <= wdata0;
            if (wr1_ok) mem[waddr1] <= wdata1;
        end
    end

    gpr_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock     (clock),
        .rst_n     (rst_n),
        .clr0_en   (we0),
        .clr0_addr (waddr0),
        .clr1_en   (we1),
        .clr1_addr (waddr1),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    always_comb begin : read_mux
        logic [ADDR_W-1:0] idx;
        logic              zr_hit;
        idx     = '0;
        zr_hit  = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            idx    = rd_addr[i*ADDR_W +: ADDR_W];
            zr_hit = ZR && (idx == '0);
            if (!zr_hit) begin
                rd_data[i*DATA_W +: DATA_W] = mem[idx];
                rd_busy[i]                  = busy[idx];
`ifdef GPR_BYPASS_EN
                if (we0 && (waddr0 == idx)) begin
                    rd_data[i*DATA_W +: DATA_W] = wdata0;
                    rd_busy[i]                  = 1'b0;
                end
                if (we1 && (waddr1 == idx)) begin
                    rd_data[i*DATA_W +: DATA_W] = wdata1;
                    rd_busy[i]                  = 1'b0;
                end
`else
`endif
            end
        end
    end

endmodule
